// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req0)
// and the load/multi-cycle unit (req1), with a registered write and saturating statistics.
module regfile_wb_arbiter #(
  parameter int ADDR_W            = 5,
  parameter int DATA_W            = 32,
  parameter int CNT_W             = 16,
  parameter int ZERO_REG_WRITABLE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              hold,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  output logic              last_grant,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic              gnt0_s;
  logic              gnt1_s;
  logic              xfer_s;
  logic              conflict_s;
  logic              wr_ok_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  logic              we_r;
  logic [ADDR_W-1:0] wreg_r;
  logic [DATA_W-1:0] wdata_r;
  logic              last_grant_r;
  logic [CNT_W-1:0]  g0_cnt_r;
  logic [CNT_W-1:0]  g1_cnt_r;
  logic [CNT_W-1:0]  cf_cnt_r;

  // Grant decision: reset and hold block everything; on conflict the requester not granted last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset || hold) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      gnt0_s = last_grant_r;
      gnt1_s = ~last_grant_r;
    end else begin
      gnt0_s = req0_valid;
      gnt1_s = req1_valid;
    end
  end

  // Winner's payload and whether it actually reaches the regfile.
  always_comb begin
    sel_addr_s = req0_addr;
    sel_data_s = req0_data;
    if (gnt1_s) begin
      sel_addr_s = req1_addr;
      sel_data_s = req1_data;
    end else begin
      sel_addr_s = req0_addr;
      sel_data_s = req0_data;
    end
    wr_ok_s    = (ZERO_REG_WRITABLE != 0) || (sel_addr_s != {ADDR_W{1'b0}});
    xfer_s     = gnt0_s | gnt1_s;
    conflict_s = req0_valid & req1_valid & ~hold & ~reset;
  end

  // Registered write port; addr/data hold their last written values between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      wreg_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      we_r <= xfer_s & wr_ok_s;
      if (xfer_s && wr_ok_s) begin
        wreg_r  <= sel_addr_s;
        wdata_r <= sel_data_s;
      end
    end
  end

  // Round-robin pointer and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
      g0_cnt_r     <= {CNT_W{1'b0}};
      g1_cnt_r     <= {CNT_W{1'b0}};
      cf_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      if (xfer_s) begin
        last_grant_r <= gnt1_s;
      end
      if (gnt0_s) begin
        g0_cnt_r <= sat_inc(g0_cnt_r);
      end
      if (gnt1_s) begin
        g1_cnt_r <= sat_inc(g1_cnt_r);
      end
      if (conflict_s) begin
        cf_cnt_r <= sat_inc(cf_cnt_r);
      end
    end
  end

  assign req0_ready   = gnt0_s;
  assign req1_ready   = gnt1_s;
  assign write_enable = we_r;
  assign write_reg    = wreg_r;
  assign write_data   = wdata_r;
  assign last_grant   = last_grant_r;
  assign grant0_cnt   = g0_cnt_r;
  assign grant1_cnt   = g1_cnt_r;
  assign conflict_cnt = cf_cnt_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: three instances (default, reg 0 writable, 2-bit counters)
// share one stimulus stream and are checked against a cycle model through expected-write queues.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset, hold, req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;

  logic          req0_ready, req1_ready, write_enable, last_grant;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [CW-1:0] grant0_cnt, grant1_cnt, conflict_cnt;

  logic          z_r0_ready, z_r1_ready, z_we, z_last;
  logic [AW-1:0] z_reg;
  logic [DW-1:0] z_data;
  logic [CW-1:0] z_g0, z_g1, z_cf;

  logic          c_r0_ready, c_r1_ready, c_we, c_last;
  logic [AW-1:0] c_reg;
  logic [DW-1:0] c_data;
  logic [1:0]    c_g0, c_g1, c_cf;

  wr_t exp_q[$];
  wr_t expz_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic          m_last;
  logic [AW-1:0] m_reg, mz_reg;
  logic [DW-1:0] m_data, mz_data;
  int            m_g0, m_g1, m_cf, m_g0c;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .hold(hold), .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
    .last_grant(last_grant), .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
    .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.ZERO_REG_WRITABLE(1)) dut_z (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(z_r0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(z_r1_ready),
    .hold(hold), .write_reg(z_reg), .write_data(z_data), .write_enable(z_we),
    .last_grant(z_last), .grant0_cnt(z_g0), .grant1_cnt(z_g1), .conflict_cnt(z_cf)
  );

  regfile_wb_arbiter #(.CNT_W(2)) dut_c (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(c_r0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(c_r1_ready),
    .hold(hold), .write_reg(c_reg), .write_data(c_data), .write_enable(c_we),
    .last_grant(c_last), .grant0_cnt(c_g0), .grant1_cnt(c_g1), .conflict_cnt(c_cf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  // One clock: check ready against the model, enqueue the expected write, then check after the edge.
  task automatic step();
    logic e0, e1;
    wr_t  w, wz;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset && !hold) begin
      if (req0_valid && req1_valid) begin
        e0 = m_last;
        e1 = ~m_last;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
    w  = '{we: 1'b0, r: m_reg,  d: m_data};
    wz = '{we: 1'b0, r: mz_reg, d: mz_data};
    if (reset) begin
      w  = '{we: 1'b0, r: '0, d: '0};
      wz = w;
      m_last = 1'b1;
      m_g0 = 0; m_g1 = 0; m_cf = 0; m_g0c = 0;
    end else begin
      if (req0_valid && req1_valid && !hold) m_cf = sat(m_cf, 65535);
      if (e0) begin
        m_last = 1'b0;
        m_g0   = sat(m_g0, 65535);
        m_g0c  = sat(m_g0c, 3);
        wz = '{we: 1'b1, r: req0_addr, d: req0_data};
        if (req0_addr != 5'd0) w = wz;
      end
      if (e1) begin
        m_last = 1'b1;
        m_g1   = sat(m_g1, 65535);
        wz = '{we: 1'b1, r: req1_addr, d: req1_data};
        if (req1_addr != 5'd0) w = wz;
      end
    end
    m_reg = w.r;   m_data = w.d;
    mz_reg = wz.r; mz_data = wz.d;
    exp_q.push_back(w);
    expz_q.push_back(wz);
    @(posedge clk);
    #1;
    w  = exp_q.pop_front();
    wz = expz_q.pop_front();
    chk("write_enable", {63'd0, write_enable}, {63'd0, w.we});
    chk("write_reg",    {59'd0, write_reg},    {59'd0, w.r});
    chk("write_data",   {32'd0, write_data},   {32'd0, w.d});
    chk("last_grant",   {63'd0, last_grant},   {63'd0, m_last});
    chk("grant0_cnt",   {48'd0, grant0_cnt},   64'(m_g0));
    chk("grant1_cnt",   {48'd0, grant1_cnt},   64'(m_g1));
    chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cf));
    chk("z_write_enable", {63'd0, z_we}, {63'd0, wz.we});
    chk("z_write_reg",    {59'd0, z_reg}, {59'd0, wz.r});
    chk("z_write_data",   {32'd0, z_data}, {32'd0, wz.d});
    chk("c_grant0_cnt",   {62'd0, c_g0}, 64'(m_g0c));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    m_last = 1'b1; m_reg = 5'd0; m_data = 32'd0; mz_reg = 5'd0; mz_data = 32'd0;
    m_g0 = 0; m_g1 = 0; m_cf = 0; m_g0c = 0;
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Single ALU write-back: one-cycle latency, then write_enable drops.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    step();
    req0_valid = 1'b0;
    step();
    step();

    // Continuous conflict: alternating grants starting with req0.
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_00A1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_00B2;
    repeat (4) step();
    chk("t2_conflict_cnt", {48'd0, conflict_cnt}, 64'd4);
    chk("t2_grant0_cnt",   {48'd0, grant0_cnt},   64'd2);
    chk("t2_grant1_cnt",   {48'd0, grant1_cnt},   64'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Write to register 0 from the load unit.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    step();
    req1_valid = 1'b0;
    step();

    // Hold freezes arbitration; release lets the other requester win.
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h1010_1010;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h1111_1111;
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    step();
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Same destination on both sides in one cycle.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9999_0000;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0000_9999;
    step();
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Reset right behind a transfer drops the pending write; requests during reset are refused.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    req0_valid = 1'b0;
    step();

    // Counter saturation on the 2-bit instance.
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0003;
    repeat (6) step();
    chk("t6_c_grant0_sat", {62'd0, c_g0}, 64'd3);
    req0_valid = 1'b0;
    step();

    // Short burst of random traffic.
    for (int i = 0; i < 40; i++) begin
      req0_valid = 1'($urandom_range(1, 0));
      req1_valid = 1'($urandom_range(1, 0));
      hold       = ($urandom_range(7, 0) == 0);
      req0_addr  = 5'($urandom_range(31, 0));
      req1_addr  = 5'($urandom_range(31, 0));
      req0_data  = $urandom;
      req1_data  = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
